ball_ctrl: RTL

BALL_CTRL -- requirements
Module: ball_ctrl

---
 rtl/pong_pkg.sv | 37 +++
 rtl/ball_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pong_pkg
//  Purpose  : Shared Pong geometry defaults and ball state encoding used by
//             the ball controller and paddle logic.
//  Contents : H_RES, V_RES, BALL_SIZE, paddle geometry, SPEED, HOLD_FRAMES
//             defaults, datapath widths, ball_state_e.
//  Revision : 1.0 - initial release
// ============================================================================
package pong_pkg;

    // Screen and sprite geometry defaults (pixels)
    localparam int H_RES       = 640;
    localparam int V_RES       = 480;
    localparam int BALL_SIZE   = 8;
    localparam int PADDLE_W    = 8;
    localparam int PADDLE_H    = 64;
    localparam int PADDLE_L_X  = 16;
    localparam int PADDLE_R_X  = 616;

    // Motion defaults
    localparam int SPEED       = 2;
    localparam int HOLD_FRAMES = 60;

    // Datapath widths: positions are 11 bits, all arithmetic is done in 12
    // bits so sums and differences never wrap.
    localparam int POS_W   = 11;
    localparam int ARITH_W = 12;

    typedef enum logic [1:0] {
        BALL_IDLE   = 2'd0,
        BALL_PLAY   = 2'd1,
        BALL_SCORED = 2'd2
    } ball_state_e;

endpackage : pong_pkg
`default_nettype wire

// File: rtl/ball_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ball_ctrl
//  Purpose  : Pong ball controller. Holds the ball at centre until served,
//             moves it once per frame, bounces off walls and paddles, and
//             freezes it for HOLD_FRAMES frames after a point is scored.
//  Ports    : clk         in   pixel clock
//             rst         in   asynchronous active-high reset
//             frame_tick  in   one-cycle pulse at frame start
//             serve       in   launch request (level, honoured in IDLE only)
//             paddle_l_y  in   left paddle top y  (11 bits)
//             paddle_r_y  in   right paddle top y (11 bits)
//             ball_x      out  ball top-left x    (11 bits)
//             ball_y      out  ball top-left y    (11 bits)
//             score_l     out  one-cycle pulse, left player scored
//             score_r     out  one-cycle pulse, right player scored
//             hit         out  one-cycle pulse on paddle contact
//             playing     out  high while in PLAY
//  Config   : BALL_SPEEDUP_EN - when defined, each paddle hit raises the
//             speed by 1 px/frame, saturating at 2*SPEED.
//  Revision : 1.0 - initial release
// ============================================================================
module ball_ctrl
    import pong_pkg::*;
#(
    parameter int H_RES       = pong_pkg::H_RES,
    parameter int V_RES       = pong_pkg::V_RES,
    parameter int BALL_SIZE   = pong_pkg::BALL_SIZE,
    parameter int PADDLE_W    = pong_pkg::PADDLE_W,
    parameter int PADDLE_H    = pong_pkg::PADDLE_H,
    parameter int PADDLE_L_X  = pong_pkg::PADDLE_L_X,
    parameter int PADDLE_R_X  = pong_pkg::PADDLE_R_X,
    parameter int SPEED       = pong_pkg::SPEED,
    parameter int HOLD_FRAMES = pong_pkg::HOLD_FRAMES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic             serve,
    input  logic [POS_W-1:0] paddle_l_y,
    input  logic [POS_W-1:0] paddle_r_y,
    output logic [POS_W-1:0] ball_x,
    output logic [POS_W-1:0] ball_y,
    output logic             score_l,
    output logic             score_r,
    output logic             hit,
    output logic             playing
);

    localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    localparam logic [ARITH_W-1:0] C_CENTRE_X = ARITH_W'((H_RES - BALL_SIZE) / 2);
    localparam logic [ARITH_W-1:0] C_CENTRE_Y = ARITH_W'((V_RES - BALL_SIZE) / 2);
    localparam logic [ARITH_W-1:0] C_MAX_X    = ARITH_W'(H_RES - BALL_SIZE);
    localparam logic [ARITH_W-1:0] C_MAX_Y    = ARITH_W'(V_RES - BALL_SIZE);
    localparam logic [ARITH_W-1:0] C_L_FACE   = ARITH_W'(PADDLE_L_X + PADDLE_W);
    localparam logic [ARITH_W-1:0] C_R_FACE   = ARITH_W'(PADDLE_R_X);
    localparam logic [ARITH_W-1:0] C_R_STOP   = ARITH_W'(PADDLE_R_X - BALL_SIZE);
    localparam logic [ARITH_W-1:0] C_BALL     = ARITH_W'(BALL_SIZE);
    localparam logic [ARITH_W-1:0] C_PAD_H    = ARITH_W'(PADDLE_H);
    localparam logic [ARITH_W-1:0] C_SPEED    = ARITH_W'(SPEED);
    localparam logic [HOLD_W-1:0]  C_HOLD     = HOLD_W'(HOLD_FRAMES - 1);

    ball_state_e        state;
    logic               dir_x;      // 1 = right
    logic               dir_y;      // 1 = down
    logic [HOLD_W-1:0]  hold_cnt;
    logic [ARITH_W-1:0] speed;

`ifdef BALL_SPEEDUP_EN
    localparam logic [ARITH_W-1:0] C_SPEED_MAX = ARITH_W'(2 * SPEED);
`else
    assign speed = C_SPEED;
`endif

    // ------------------------------------------------------------------
    // Next-position evaluation for one frame of motion in PLAY
    // ------------------------------------------------------------------
    logic [ARITH_W-1:0] bx, by, pl, pr;
    logic               ov_l, ov_r;
    logic [POS_W-1:0]   nx, ny;
    logic               ndx, ndy, n_hit, n_sl, n_sr;

    assign bx = {1'b0, ball_x};
    assign by = {1'b0, ball_y};
    assign pl = {1'b0, paddle_l_y};
    assign pr = {1'b0, paddle_r_y};

    // Vertical overlap uses the pre-update ball_y.
    assign ov_l = (by + C_BALL > pl) && (by < pl + C_PAD_H);
    assign ov_r = (by + C_BALL > pr) && (by < pr + C_PAD_H);

    always_comb begin
        nx    = ball_x;
        ny    = ball_y;
        ndx   = dir_x;
        ndy   = dir_y;
        n_hit = 1'b0;
        n_sl  = 1'b0;
        n_sr  = 1'b0;

        // Horizontal: paddle contact wins over a miss. On a miss dir_x is
        // left unchanged, which already points toward the conceding side.
        if (!dir_x) begin
            // bx - speed <= face rewritten to avoid underflow
            if ((bx <= C_L_FACE + speed) && ov_l) begin
                nx    = POS_W'(C_L_FACE);
                ndx   = 1'b1;
                n_hit = 1'b1;
            end else if (bx < speed) begin
                nx    = '0;
                n_sr  = 1'b1;
            end else begin
                nx    = POS_W'(bx - speed);
            end
        end else begin
            if ((bx + speed + C_BALL >= C_R_FACE) && ov_r) begin
                nx    = POS_W'(C_R_STOP);
                ndx   = 1'b0;
                n_hit = 1'b1;
            end else if (bx + speed > C_MAX_X) begin
                nx    = POS_W'(C_MAX_X);
                n_sl  = 1'b1;
            end else begin
                nx    = POS_W'(bx + speed);
            end
        end

        // Vertical: walls clamp and reflect in the same frame as any
        // horizontal event, so a corner hit flips both directions.
        if (!dir_y) begin
            if (by < speed) begin
                ny  = '0;
                ndy = 1'b1;
            end else begin
                ny  = POS_W'(by - speed);
            end
        end else begin
            if (by + speed >= C_MAX_Y) begin
                ny  = POS_W'(C_MAX_Y);
                ndy = 1'b0;
            end else begin
                ny  = POS_W'(by + speed);
            end
        end
    end

    // ------------------------------------------------------------------
    // State machine, position registers, hold counter, registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BALL_IDLE;
            ball_x   <= POS_W'(C_CENTRE_X);
            ball_y   <= POS_W'(C_CENTRE_Y);
            dir_x    <= 1'b1;
            dir_y    <= 1'b1;
            hold_cnt <= '0;
            score_l  <= 1'b0;
            score_r  <= 1'b0;
            hit      <= 1'b0;
            playing  <= 1'b0;
`ifdef BALL_SPEEDUP_EN
            speed    <= C_SPEED;
`endif
        end else begin
            score_l <= 1'b0;
            score_r <= 1'b0;
            hit     <= 1'b0;
            case (state)
                BALL_IDLE: begin
                    ball_x <= POS_W'(C_CENTRE_X);
                    ball_y <= POS_W'(C_CENTRE_Y);
                    // Launch only; a coincident frame_tick does not move.
                    if (serve) begin
                        state   <= BALL_PLAY;
                        playing <= 1'b1;
                    end
                end
                BALL_PLAY: begin
                    if (frame_tick) begin
                        ball_x  <= nx;
                        ball_y  <= ny;
                        dir_x   <= ndx;
                        dir_y   <= ndy;
                        hit     <= n_hit;
                        score_l <= n_sl;
                        score_r <= n_sr;
                        if (n_sl || n_sr) begin
                            state    <= BALL_SCORED;
                            playing  <= 1'b0;
                            hold_cnt <= C_HOLD;
                        end
`ifdef BALL_SPEEDUP_EN
                        if (n_hit && (speed < C_SPEED_MAX)) begin
                            speed <= speed + 1'b1;
                        end
`endif
                    end
                end
                BALL_SCORED: begin
                    if (frame_tick) begin
                        if (hold_cnt == '0) begin
                            state  <= BALL_IDLE;
                            ball_x <= POS_W'(C_CENTRE_X);
                            ball_y <= POS_W'(C_CENTRE_Y);
`ifdef BALL_SPEEDUP_EN
                            speed  <= C_SPEED;
`endif
                        end else begin
                            hold_cnt <= hold_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= BALL_IDLE;
                    playing <= 1'b0;
                end
            endcase
        end
    end

endmodule : ball_ctrl
`default_nettype wire
